spike_stream_driver: RTL and testbench

- Input-side counterpart of the LIF neuron controller.
- Reads an N_PIXELS image from a synchronous pixel buffer and rate-encodes each pixel into a spike.
- Drives the neuron with the calc_en / spike_valid handshake and consumes data_valid as per-pixel completion.
- Repeats the frame for N_STEPS timesteps and reports step and frame completion.

---
 rtl/spike_stream_driver.sv | 133 +++++++++++++
 tb/tb_spike_stream_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_stream_driver.sv
// Rate-encodes a pixel buffer image into spikes for the LIF neuron controller, repeating the frame N_STEPS times.
// Optional build macro RATE_CODE_EN selects LFSR rate coding; otherwise pixels are binary-thresholded at BIN_THRESH.
module spike_stream_driver #(
  parameter int          N_PIXELS   = 784,
  parameter int          PIX_W      = 8,
  parameter int          N_STEPS    = 16,
  parameter int          ADDR_W     = 10,
  parameter int          STEP_W     = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          BIN_THRESH = 128,
  parameter int          TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              calc_en,
  output logic              spike_valid,
  output logic              spike,
  input  logic              data_valid,
  output logic              busy,
  output logic [STEP_W-1:0] step_idx,
  output logic              step_done,
  output logic              frame_done,
  output logic              timeout_err
);

  // state    | meaning
  // IDLE     | waiting for start
  // FETCH    | read strobe to the pixel buffer
  // CAPTURE  | pixel data returns; spike is encoded and registered
  // ISSUE    | one-cycle calc_en to the neuron
  // PRESENT  | spike_valid held until data_valid or timeout
  // ADVANCE  | step pixel / timestep indices
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_ISSUE, S_PRESENT, S_ADVANCE
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [PIX_W:0] THRESH = BIN_THRESH[PIX_W:0];
  // A misconfigured instance never leaves IDLE.
  localparam bit CFG_OK = (LFSR_SEED != 16'h0000) && ((2**ADDR_W) >= N_PIXELS) &&
                          ((2**STEP_W) >= N_STEPS) && (BIN_THRESH <= (2**PIX_W)) && (TIMEOUT > 0);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pix_idx;
  logic [STEP_W-1:0]   step_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                last_pix, last_step, wait_max, spike_enc;

  assign last_pix  = (pix_idx == ADDR_W'(N_PIXELS - 1));
  assign last_step = (step_q == STEP_W'(N_STEPS - 1));
  assign wait_max  = (wait_cnt == WAIT_W'(TIMEOUT - 1));

`ifdef RATE_CODE_EN
  logic [15:0] lfsr, lfsr_nxt;

  // Galois form of x^16+x^14+x^13+x^11+1; never reaches zero from a non-zero seed.
  assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign spike_enc = (lfsr_nxt[PIX_W-1:0] < pix_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lfsr <= LFSR_SEED;
    else if (state == S_CAPTURE) lfsr <= lfsr_nxt;
  end
`else
  assign spike_enc = ({1'b0, pix_data} >= THRESH);
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start && CFG_OK) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (data_valid)    state_nxt = S_ADVANCE;
        else if (wait_max) state_nxt = S_IDLE;
      end
      S_ADVANCE: state_nxt = (last_pix && last_step) ? S_IDLE : S_FETCH;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pix_idx     <= '0;
      step_q      <= '0;
      wait_cnt    <= '0;
      spike       <= 1'b0;
      pix_rd_en   <= 1'b0;
      calc_en     <= 1'b0;
      spike_valid <= 1'b0;
      step_done   <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Strobes are decoded from the next state so they are flop outputs aligned with the state.
      pix_rd_en   <= (state_nxt == S_FETCH);
      calc_en     <= (state_nxt == S_ISSUE);
      spike_valid <= (state_nxt == S_PRESENT);
      step_done   <= (state == S_ADVANCE) && last_pix;
      frame_done  <= (state == S_ADVANCE) && last_pix && last_step;

      if (state == S_PRESENT && state_nxt == S_PRESENT) wait_cnt <= wait_cnt + 1'b1;
      else                                              wait_cnt <= '0;

      if (state == S_IDLE && start && CFG_OK)                timeout_err <= 1'b0;
      else if (state == S_PRESENT && !data_valid && wait_max) timeout_err <= 1'b1;

      if (state == S_CAPTURE) spike <= spike_enc;

      if (state == S_ADVANCE) begin
        if (last_pix) begin
          pix_idx <= '0;
          step_q  <= last_step ? '0 : step_q + 1'b1;
        end else begin
          pix_idx <= pix_idx + 1'b1;
        end
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign pix_addr = pix_idx;
  assign step_idx = step_q;

endmodule

// File: tb/tb_spike_stream_driver.sv
// Directed bench for spike_stream_driver: a 4-pixel/2-step instance for handshake corners and a full-size one.
module tb_spike_stream_driver;
  localparam int          TO   = 64;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef RATE_CODE_EN
  localparam bit RATE_MODE = 1'b1;
`else
  localparam bit RATE_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       start_s = 1'b0, pix_rd_en_s, calc_en_s, spike_valid_s, spike_s, data_valid_s;
  logic       busy_s, step_done_s, frame_done_s, timeout_err_s;
  logic [9:0] pix_addr_s;
  logic [7:0] pix_data_s = 8'd0;
  logic [4:0] step_idx_s;

  logic       start_l = 1'b0, pix_rd_en_l, calc_en_l, spike_valid_l, spike_l, data_valid_l;
  logic       busy_l, step_done_l, frame_done_l, timeout_err_l;
  logic [9:0] pix_addr_l;
  logic [7:0] pix_data_l = 8'd0;
  logic [4:0] step_idx_l;

  spike_stream_driver #(.N_PIXELS(4), .N_STEPS(2), .TIMEOUT(TO)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .pix_rd_en(pix_rd_en_s), .pix_addr(pix_addr_s),
    .pix_data(pix_data_s), .calc_en(calc_en_s), .spike_valid(spike_valid_s), .spike(spike_s),
    .data_valid(data_valid_s), .busy(busy_s), .step_idx(step_idx_s), .step_done(step_done_s),
    .frame_done(frame_done_s), .timeout_err(timeout_err_s));

  spike_stream_driver dut_l (
    .clk(clk), .rst(rst), .start(start_l), .pix_rd_en(pix_rd_en_l), .pix_addr(pix_addr_l),
    .pix_data(pix_data_l), .calc_en(calc_en_l), .spike_valid(spike_valid_l), .spike(spike_l),
    .data_valid(data_valid_l), .busy(busy_l), .step_idx(step_idx_l), .step_done(step_done_l),
    .frame_done(frame_done_l), .timeout_err(timeout_err_l));

  typedef struct {
    logic [9:0] addr;
    logic [4:0] step;
    logic [7:0] pix;
    logic       spk;
  } vec_t;
  vec_t tbl [8];

  logic [7:0] pix_mem [4];
  logic [7:0] large_val = 8'd0;

  // Synchronous pixel buffers: data one cycle after the read strobe.
  always @(posedge clk) if (pix_rd_en_s) pix_data_s <= pix_mem[pix_addr_s[1:0]];
  always @(posedge clk) if (pix_rd_en_l) pix_data_l <= large_val;

  // Ideal neurons: data_valid in the 4th cycle of spike_valid.
  logic resp_on_s = 1'b0, resp_on_l = 1'b0, dv_s = 1'b0, dv_l = 1'b0, man_dv_s = 1'b0;
  int   cnt_s = 0, cnt_l = 0;
  always @(negedge clk) begin
    if (resp_on_s && spike_valid_s) begin
      dv_s  = (cnt_s == 3);
      cnt_s = (cnt_s == 3) ? 0 : cnt_s + 1;
    end else begin
      dv_s  = 1'b0;
      cnt_s = 0;
    end
    if (resp_on_l && spike_valid_l) begin
      dv_l  = (cnt_l == 3);
      cnt_l = (cnt_l == 3) ? 0 : cnt_l + 1;
    end else begin
      dv_l  = 1'b0;
      cnt_l = 0;
    end
  end
  assign data_valid_s = dv_s | man_dv_s;
  assign data_valid_l = dv_l;

  logic [15:0] lfsr_s, lfsr_l;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic exp_spike(input logic [7:0] pix, input logic [15:0] l);
    return RATE_MODE ? (l[7:0] < pix) : (pix >= 8'd128);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start_s();
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
  endtask

  task automatic pulse_start_l();
    start_l = 1'b1;
    @(posedge clk);
    #1 start_l = 1'b0;
  endtask

  task automatic run_large(input int npix, input logic [7:0] val, output int bad, output int seen,
                           output logic [9:0] first_addr);
    logic sv_prev;
    bit   got_first;
    large_val  = val;
    bad        = 0;
    seen       = 0;
    got_first  = 1'b0;
    first_addr = '1;
    sv_prev    = spike_valid_l;
    for (int c = 0; c < npix * 12 + 40 && seen < npix; c++) begin
      tick();
      if (pix_rd_en_l && !got_first) begin
        first_addr = pix_addr_l;
        got_first  = 1'b1;
      end
      if (spike_valid_l && !sv_prev) begin
        lfsr_l = lfsr_step(lfsr_l);
        if (spike_l !== exp_spike(val, lfsr_l)) bad++;
        seen++;
      end
      sv_prev = spike_valid_l;
    end
  endtask

  initial begin
    int   k, sp, n_calc, n_sd, n_fd, n, bad, seen;
    bit   wide, done, found, calc_prev, sv_prev, fd_prev;
    logic [9:0] fa;

    tbl[0] = '{10'd0, 5'd0, 8'd0,   1'b0};
    tbl[1] = '{10'd1, 5'd0, 8'd127, 1'b0};
    tbl[2] = '{10'd2, 5'd0, 8'd128, 1'b1};
    tbl[3] = '{10'd3, 5'd0, 8'd255, 1'b1};
    tbl[4] = '{10'd0, 5'd1, 8'd0,   1'b0};
    tbl[5] = '{10'd1, 5'd1, 8'd127, 1'b0};
    tbl[6] = '{10'd2, 5'd1, 8'd128, 1'b1};
    tbl[7] = '{10'd3, 5'd1, 8'd255, 1'b1};
    for (int i = 0; i < 4; i++) pix_mem[i] = tbl[i].pix;

    // Reset state
    tick(); tick();
    chk("reset_outputs_s", {pix_rd_en_s, pix_addr_s, calc_en_s, spike_valid_s, spike_s, busy_s,
                            step_idx_s, step_done_s, frame_done_s, timeout_err_s}, 0);
    chk("reset_outputs_l", {pix_rd_en_l, pix_addr_l, calc_en_l, spike_valid_l, spike_l, busy_l,
                            step_idx_l, step_done_l, frame_done_l, timeout_err_l}, 0);
    rst = 1'b0;
    tick();

    // Full frame on the small instance, one table row per pixel
    resp_on_s = 1'b1;
    lfsr_s = SEED;
    k = 0; sp = 0; n_calc = 0; n_sd = 0; n_fd = 0;
    wide = 0; done = 0; calc_prev = 0; sv_prev = 0; fd_prev = 0;
    pulse_start_s();
    chk("busy_after_start", busy_s, 1);
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      if (pix_rd_en_s) begin
        if (k < 8) begin
          chk("pix_addr_seq", pix_addr_s, tbl[k].addr);
          chk("step_idx_seq", step_idx_s, tbl[k].step);
        end
        k++;
      end
      if (spike_valid_s && !sv_prev) begin
        lfsr_s = lfsr_step(lfsr_s);
        if (sp < 8) chk("spike_seq", spike_s, RATE_MODE ? exp_spike(tbl[sp].pix, lfsr_s) : tbl[sp].spk);
        sp++;
      end
      if (calc_en_s) begin
        n_calc++;
        if (calc_prev) wide = 1'b1;
      end
      if (step_done_s) n_sd++;
      if (frame_done_s) n_fd++;
      if (fd_prev) begin
        chk("busy_after_frame_done", busy_s, 0);
        done = 1'b1;
      end
      calc_prev = calc_en_s;
      sv_prev   = spike_valid_s;
      fd_prev   = frame_done_s;
    end
    chk("frame_finished", done, 1);
    chk("fetch_count", k, 8);
    chk("calc_en_pulses", n_calc, 8);
    chk("calc_en_width", wide, 0);
    chk("step_done_pulses", n_sd, 2);
    chk("frame_done_pulses", n_fd, 1);
    chk("step_idx_cleared", step_idx_s, 0);

    // Handshake timeout
    resp_on_s = 1'b0;
    pulse_start_s();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (spike_valid_s) found = 1'b1;
    end
    chk("spike_valid_rise", found, 1);
    n = 0; found = 0;
    while (!found && n < TO + 10) begin
      tick();
      n++;
      if (timeout_err_s) found = 1'b1;
    end
    chk("timeout_latency", n, TO);
    chk("timeout_idle", {busy_s, spike_valid_s}, 0);
    chk("timeout_pix_kept", pix_addr_s, 0);
    tick(); tick(); tick();
    chk("timeout_sticky", timeout_err_s, 1);

    // Restart clears the error; data_valid outside PRESENT must not advance
    pulse_start_s();
    chk("timeout_cleared", timeout_err_s, 0);
    man_dv_s = 1'b1;
    tick();
    chk("early_dv_fetch", {pix_rd_en_s, pix_addr_s}, {1'b1, 10'd0});
    tick();
    chk("early_dv_capture", {pix_rd_en_s, pix_addr_s}, {1'b0, 10'd0});
    tick();
    chk("early_dv_issue", {calc_en_s, pix_addr_s}, {1'b1, 10'd0});
    tick();
    chk("early_dv_present", {spike_valid_s, pix_addr_s}, {1'b1, 10'd0});
    man_dv_s = 1'b0;
    tick(); tick();
    chk("present_holds", {spike_valid_s, pix_addr_s}, {1'b1, 10'd0});
    man_dv_s = 1'b1;
    tick();
    chk("advance_drops_sv", spike_valid_s, 0);
    man_dv_s = 1'b0;
    tick();
    chk("next_pixel_fetch", {pix_rd_en_s, pix_addr_s}, {1'b1, 10'd1});

    // Full-size instance: all-zero step, all-255 step, then reset in PRESENT of pixel 300
    resp_on_l = 1'b1;
    lfsr_l = SEED;
    pulse_start_l();
    run_large(784, 8'd0, bad, seen, fa);
    chk("zero_pix_seen", seen, 784);
    chk("zero_pix_spikes_bad", bad, 0);
    run_large(784, 8'd255, bad, seen, fa);
    chk("full_pix_seen", seen, 784);
    chk("full_pix_spikes_bad", bad, 0);
    chk("full_pix_first_addr", fa, 0);
    run_large(301, 8'd0, bad, seen, fa);
    chk("pix300_state", {spike_valid_l, step_idx_l, pix_addr_l}, {1'b1, 5'd2, 10'd300});
    rst = 1'b1;
    #1;
    chk("async_rst_outputs_l", {pix_rd_en_l, pix_addr_l, calc_en_l, spike_valid_l, spike_l, busy_l,
                                step_idx_l, step_done_l, frame_done_l, timeout_err_l}, 0);
    chk("async_rst_outputs_s", {pix_rd_en_s, spike_valid_s, busy_s, timeout_err_s}, 0);
    lfsr_l = SEED;
    tick(); tick();
    chk("rst_no_strobes", {pix_rd_en_l, calc_en_l}, 0);
    rst = 1'b0;
    tick();
    pulse_start_l();
    chk("restart_step_idx", step_idx_l, 0);
    run_large(8, 8'd255, bad, seen, fa);
    chk("restart_first_addr", fa, 0);
    chk("restart_seen", seen, 8);
    chk("restart_spikes_bad", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
